// File: rtl/rx_uart_pkg.sv
// Shared types and helpers for the UART frame receiver: FSM states, parity modes, FIFO count width.
package rx_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        PUSH,
        WAIT_IDLE
    } rx_state_t;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rx_uart_fifo.sv
// Synchronous show-ahead FIFO: head word visible on rdata while non-empty, 0 when empty.
module rx_uart_fifo
    import rx_uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic                            pop,
    input  logic [WIDTH-1:0]                wdata,
    output logic [WIDTH-1:0]                rdata,
    output logic                            full,
    output logic                            empty,
    output logic [count_width(DEPTH)-1:0]   count
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CNTW'(do_push) - CNTW'(do_pop);
        end
    end

    assign full  = (count == CNTW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/rx_uart_frame_receiver.sv
// UART receiver: synchroniser, mid-bit sampling deframer and output FIFO.
// Define RX_UART_MAJORITY_EN for 2-of-3 majority bit decisions around the mid-bit point.
module rx_uart_frame_receiver
    import rx_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                bit_serial,
    output logic [DATA_BITS-1:0]                out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [count_width(FIFO_DEPTH)-1:0]  fifo_count,
    output logic                                err_frame,
    output logic                                err_parity,
    output logic                                err_overrun
);

    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW   = $clog2(DATA_BITS);

    rx_state_t           state;
    logic                sync1;
    logic                sync2;
    logic                prev;
    logic [CW-1:0]       clk_cnt;
    logic [BW-1:0]       bit_cnt;
    logic                stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                parity_bad;
    logic                bit_val;
    logic                tick;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;

    // Decisions are taken one clock after mid-bit so both sampling modes share identical timing.
`ifdef RX_UART_MAJORITY_EN
    logic prev2;

    always_ff @(posedge clk) begin
        prev2 <= rst ? 1'b1 : prev;
    end

    assign bit_val = (sync2 & prev) | (sync2 & prev2) | (prev & prev2);
`else
    assign bit_val = prev;
`endif

    assign tick = (state == START) ? (clk_cnt == CW'(HALF)) : (clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign push = (state == PUSH);
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            prev        <= 1'b1;
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            stop_cnt    <= 1'b0;
            shreg       <= '0;
            parity_bad  <= 1'b0;
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            sync1       <= bit_serial;
            sync2       <= sync1;
            prev        <= sync2;
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_overrun <= 1'b0;
            clk_cnt     <= tick ? '0 : clk_cnt + CW'(1);

            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (prev && !sync2) begin
                        state <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        bit_cnt <= '0;
                        state   <= bit_val ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg      <= {bit_val, shreg[DATA_BITS-1:1]};
                        bit_cnt    <= bit_cnt + BW'(1);
                        parity_bad <= 1'b0;
                        stop_cnt   <= 1'b0;
                        if (bit_cnt == BW'(DATA_BITS - 1)) begin
                            state <= (PARITY_MODE == PARITY_NONE) ? STOP : PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        parity_bad <= ((^shreg) ^ bit_val) != (PARITY_MODE == PARITY_ODD);
                        state      <= STOP;
                    end
                end
                STOP: begin
                    // A low stop bit wins over a parity failure and parks until the line recovers.
                    if (tick) begin
                        if (!bit_val) begin
                            err_frame <= 1'b1;
                            state     <= WAIT_IDLE;
                        end else if (stop_cnt == 1'(STOP_BITS - 1)) begin
                            if (parity_bad) begin
                                err_parity <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                state <= PUSH;
                            end
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                PUSH: begin
                    err_overrun <= full && !pop;
                    state       <= IDLE;
                end
                WAIT_IDLE: begin
                    if (sync2) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    rx_uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (shreg),
        .rdata (out_data),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign out_valid = !empty;

endmodule
